zbb_wb: RTL and testbench



---
 rtl/zbb_wb_pkg.sv | 20 ++
 rtl/zbb_wb_fifo.sv | 88 ++++++++
 rtl/zbb_wb.sv | 110 +++++++++++
 tb/tb_zbb_wb.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/zbb_wb_pkg.sv
// Shared Zbb definitions: opcode/funct encodings plus field widths used by the
// writeback stage.
package zbb_wb_pkg;
  localparam int ZBB_XLEN = 32;
  localparam int REG_W    = 5;
  localparam logic [REG_W-1:0] X0 = '0;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_ANDN    = 7'b0100000;
  localparam logic [6:0] F7_MINMAX  = 7'b0000101;
  localparam logic [6:0] F7_ROT     = 7'b0110000;

  // A buffered result only writes the register file when it is a recognised
  // Zbb op, the decoder asked for a write, and the target is not x0.
  function automatic logic wb_we(input logic reg_write, input logic is_zbb,
                                 input logic [REG_W-1:0] rd);
    return reg_write & is_zbb & (rd != X0);
  endfunction
endpackage

// File: rtl/zbb_wb_fifo.sv
// In-order result buffer: per-entry {data, rd, we, illegal} with head/tail
// pointers, occupancy and per-slot valid bits exposed for forwarding.
module zbb_wb_fifo
  import zbb_wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = ZBB_XLEN
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            i_push,
  input  logic                            i_pop,
  input  logic [XLEN-1:0]                 i_data,
  input  logic [REG_W-1:0]                i_rd,
  input  logic                            i_we,
  input  logic                            i_illegal,
  output logic                            o_full,
  output logic [$clog2(DEPTH)-1:0]        o_head,
  output logic [$clog2(DEPTH):0]          o_occ,
  output logic [DEPTH-1:0]                o_vld,
  output logic [DEPTH-1:0]                o_we,
  output logic [DEPTH-1:0]                o_ill,
  output logic [DEPTH-1:0][REG_W-1:0]     o_rd,
  output logic [DEPTH-1:0][XLEN-1:0]      o_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  logic [PW-1:0]                r_head;
  logic [PW-1:0]                r_tail;
  logic [OW-1:0]                r_occ;
  logic [DEPTH-1:0]             r_vld;
  logic [DEPTH-1:0]             r_we;
  logic [DEPTH-1:0]             r_ill;
  logic [DEPTH-1:0][REG_W-1:0]  r_rd;
  logic [DEPTH-1:0][XLEN-1:0]   r_data;

  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_full = (r_occ == OW'(DEPTH));
  assign w_push = i_push & ~w_full & ~flush;
  assign w_pop  = i_pop & r_vld[r_head] & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
      r_vld  <= '0;
      r_we   <= '0;
      r_ill  <= '0;
      r_rd   <= '0;
      r_data <= '0;
    end else if (flush) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
      r_vld  <= '0;
    end else begin
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + PW'(1);
      end
      // Pointers are PW bits wide, so DEPTH being a power of two makes them wrap.
      if (w_push) begin
        r_vld[r_tail]  <= 1'b1;
        r_we[r_tail]   <= i_we;
        r_ill[r_tail]  <= i_illegal;
        r_rd[r_tail]   <= i_rd;
        r_data[r_tail] <= i_data;
        r_tail         <= r_tail + PW'(1);
      end
      r_occ <= r_occ + OW'(w_push) - OW'(w_pop);
    end
  end

  assign o_full = w_full;
  assign o_head = r_head;
  assign o_occ  = r_occ;
  assign o_vld  = r_vld;
  assign o_we   = r_we;
  assign o_ill  = r_ill;
  assign o_rd   = r_rd;
  assign o_data = r_data;
endmodule

// File: rtl/zbb_wb.sv
// Zbb writeback stage: buffers execute results, presents the oldest to the
// register file, forwards youngest matching results and counts illegal ops.
module zbb_wb
  import zbb_wb_pkg::*;
#(
  parameter int XLEN   = ZBB_XLEN,
  parameter int DEPTH  = 2,
  parameter int ICNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_result,
  input  logic                     in_isZbb,
  input  logic [REG_W-1:0]         in_rd,
  input  logic                     in_regWrite,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_data,
  output logic [REG_W-1:0]         out_rd,
  output logic                     out_we,
  output logic                     out_illegal,
  input  logic [REG_W-1:0]         fwd_rs1_addr,
  input  logic [REG_W-1:0]         fwd_rs2_addr,
  output logic                     fwd_rs1_hit,
  output logic [XLEN-1:0]          fwd_rs1_data,
  output logic                     fwd_rs2_hit,
  output logic [XLEN-1:0]          fwd_rs2_data,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [ICNT_W-1:0]        illegal_cnt
);
  localparam int PW = $clog2(DEPTH);

  logic                          w_full;
  logic [PW-1:0]                 w_head;
  logic [PW-1:0]                 w_idx;
  logic [DEPTH-1:0]              w_vld;
  logic [DEPTH-1:0]              w_we;
  logic [DEPTH-1:0]              w_ill;
  logic [DEPTH-1:0][REG_W-1:0]   w_rd;
  logic [DEPTH-1:0][XLEN-1:0]    w_data;
  logic [XLEN-1:0]               w_in_data;
  logic                          w_acc;
  logic [ICNT_W-1:0]             r_icnt;

  assign w_in_data = in_isZbb ? in_result : '0;
  assign w_acc     = in_valid & ~w_full & ~flush;

  zbb_wb_fifo #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .i_push    (in_valid),
    .i_pop     (out_ready),
    .i_data    (w_in_data),
    .i_rd      (in_rd),
    .i_we      (wb_we(in_regWrite, in_isZbb, in_rd)),
    .i_illegal (~in_isZbb),
    .o_full    (w_full),
    .o_head    (w_head),
    .o_occ     (occupancy),
    .o_vld     (w_vld),
    .o_we      (w_we),
    .o_ill     (w_ill),
    .o_rd      (w_rd),
    .o_data    (w_data)
  );

  assign in_ready    = ~w_full;
  assign out_valid   = w_vld[w_head];
  assign out_we      = w_vld[w_head] & w_we[w_head];
  assign out_illegal = w_vld[w_head] & w_ill[w_head];
  assign out_data    = w_data[w_head];
  assign out_rd      = w_rd[w_head];

  // Walk oldest to youngest from the head so a later match overrides an earlier one.
  always_comb begin
    fwd_rs1_hit  = 1'b0;
    fwd_rs1_data = '0;
    fwd_rs2_hit  = 1'b0;
    fwd_rs2_data = '0;
    w_idx        = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = w_head + PW'(k);
      if (w_vld[w_idx] && w_we[w_idx] && (fwd_rs1_addr != X0) && (w_rd[w_idx] == fwd_rs1_addr)) begin
        fwd_rs1_hit  = 1'b1;
        fwd_rs1_data = w_data[w_idx];
      end
      if (w_vld[w_idx] && w_we[w_idx] && (fwd_rs2_addr != X0) && (w_rd[w_idx] == fwd_rs2_addr)) begin
        fwd_rs2_hit  = 1'b1;
        fwd_rs2_data = w_data[w_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_icnt <= '0;
    end else if (w_acc && !in_isZbb && !(&r_icnt)) begin
      r_icnt <= r_icnt + ICNT_W'(1);
    end
  end

  assign illegal_cnt = r_icnt;
endmodule

// File: tb/tb_zbb_wb.sv
// Randomised and directed bench for zbb_wb against a queue-based model.
module tb_zbb_wb;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int ICW   = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [XLEN-1:0]   in_result = '0;
  logic              in_isZbb = 1'b0;
  logic [4:0]        in_rd = '0;
  logic              in_regWrite = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [XLEN-1:0]   out_data;
  logic [4:0]        out_rd;
  logic              out_we;
  logic              out_illegal;
  logic [4:0]        fwd_rs1_addr = '0;
  logic [4:0]        fwd_rs2_addr = '0;
  logic              fwd_rs1_hit;
  logic [XLEN-1:0]   fwd_rs1_data;
  logic              fwd_rs2_hit;
  logic [XLEN-1:0]   fwd_rs2_data;
  logic [$clog2(DEPTH):0] occupancy;
  logic [ICW-1:0]    illegal_cnt;

  int total = 0;
  int bad   = 0;

  zbb_wb #(.XLEN(XLEN), .DEPTH(DEPTH), .ICNT_W(ICW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_isZbb(in_isZbb), .in_rd(in_rd), .in_regWrite(in_regWrite),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_we(out_we), .out_illegal(out_illegal),
    .fwd_rs1_addr(fwd_rs1_addr), .fwd_rs2_addr(fwd_rs2_addr),
    .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs1_data(fwd_rs1_data),
    .fwd_rs2_hit(fwd_rs2_hit), .fwd_rs2_data(fwd_rs2_data),
    .occupancy(occupancy), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of entries plus a saturating counter.
  typedef struct {
    logic [XLEN-1:0] data;
    logic [4:0]      rd;
    logic            we;
    logic            ill;
  } ent_t;

  ent_t mq[$];
  int   micnt = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      micnt = 0;
    end else begin
      bit   do_pop;
      bit   do_push;
      ent_t e;
      do_pop  = (mq.size() > 0) && out_ready;
      do_push = in_valid && (mq.size() < DEPTH);
      if (flush) begin
        mq.delete();
      end else begin
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
          e.data = in_isZbb ? in_result : '0;
          e.rd   = in_rd;
          e.we   = in_regWrite && in_isZbb && (in_rd != 0);
          e.ill  = !in_isZbb;
          mq.push_back(e);
          if (!in_isZbb && micnt < 255) micnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    int              n;
    bit              h1, h2;
    logic [XLEN-1:0] d1, d2;
    n  = mq.size();
    h1 = 0; h2 = 0; d1 = '0; d2 = '0;
    for (int i = 0; i < n; i++) begin
      if (mq[i].we && mq[i].rd == fwd_rs1_addr && fwd_rs1_addr != 0) begin h1 = 1; d1 = mq[i].data; end
      if (mq[i].we && mq[i].rd == fwd_rs2_addr && fwd_rs2_addr != 0) begin h2 = 1; d2 = mq[i].data; end
    end
    chk("m_in_ready", in_ready, n < DEPTH);
    chk("m_occupancy", occupancy, n);
    chk("m_out_valid", out_valid, n > 0);
    chk("m_out_we", out_we, (n > 0) ? mq[0].we : 1'b0);
    chk("m_out_illegal", out_illegal, (n > 0) ? mq[0].ill : 1'b0);
    if (n > 0) begin
      chk("m_out_data", out_data, mq[0].data);
      chk("m_out_rd", out_rd, mq[0].rd);
    end
    chk("m_fwd1_hit", fwd_rs1_hit, h1);
    chk("m_fwd1_data", fwd_rs1_data, d1);
    chk("m_fwd2_hit", fwd_rs2_hit, h2);
    chk("m_fwd2_data", fwd_rs2_data, d2);
    chk("m_illegal_cnt", illegal_cnt, micnt);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [XLEN-1:0] d, input logic [4:0] rd, input logic we, input logic z);
    in_valid    = 1'b1;
    in_result   = d;
    in_rd       = rd;
    in_regWrite = we;
    in_isZbb    = z;
  endtask

  initial begin
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_illegal_cnt", illegal_cnt, 0);
    cyc();
    rst = 1'b0;

    // Single push with immediate drain
    out_ready = 1'b1;
    drive(32'h0000_00FF, 5'd5, 1'b1, 1'b1);
    cyc();
    in_valid = 1'b0;
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 32'hFF);
    chk("single_rd", out_rd, 5);
    chk("single_we", out_we, 1);
    cyc();
    chk("single_drained", occupancy, 0);

    // Back-pressure and ordering
    out_ready = 1'b0;
    drive(32'd1, 5'd1, 1'b1, 1'b1);
    cyc();
    drive(32'd2, 5'd2, 1'b1, 1'b1);
    cyc();
    chk("bp_full_ready", in_ready, 0);
    chk("bp_full_occ", occupancy, 2);
    chk("bp_head1", out_data, 1);
    drive(32'd3, 5'd3, 1'b1, 1'b1);
    cyc();
    chk("bp_blocked_occ", occupancy, 2);
    chk("bp_blocked_head", out_data, 1);
    out_ready = 1'b1;
    cyc();
    chk("bp_pop1_head", out_data, 2);
    chk("bp_pop1_occ", occupancy, 1);
    chk("bp_pop1_ready", in_ready, 1);
    cyc();
    in_valid = 1'b0;
    chk("bp_pop2_head", out_data, 3);
    chk("bp_pop2_rd", out_rd, 3);
    chk("bp_pop2_occ", occupancy, 1);
    cyc();
    chk("bp_empty", occupancy, 0);
    out_ready = 1'b0;

    // Forwarding priority, then flush with a dropped illegal push
    drive(32'h11, 5'd7, 1'b1, 1'b1);
    cyc();
    drive(32'h22, 5'd7, 1'b1, 1'b1);
    cyc();
    in_valid = 1'b0;
    fwd_rs1_addr = 5'd7;
    fwd_rs2_addr = 5'd0;
    #1;
    chk("fwd_hit_young", fwd_rs1_hit, 1);
    chk("fwd_data_young", fwd_rs1_data, 32'h22);
    chk("fwd_x0_hit", fwd_rs2_hit, 0);
    chk("fwd_x0_data", fwd_rs2_data, 0);
    flush = 1'b1;
    drive(32'h99, 5'd4, 1'b1, 1'b0);
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_occ", occupancy, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_ready", in_ready, 1);
    chk("flush_icnt", illegal_cnt, 0);
    chk("flush_fwd", fwd_rs1_hit, 0);

    // Illegal path and counter saturation
    drive(32'hDEAD_BEEF, 5'd9, 1'b1, 1'b0);
    cyc();
    in_valid = 1'b0;
    chk("ill_valid", out_valid, 1);
    chk("ill_flag", out_illegal, 1);
    chk("ill_we", out_we, 0);
    chk("ill_data", out_data, 0);
    chk("ill_cnt1", illegal_cnt, 1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    repeat (300) cyc();
    in_valid = 1'b0;
    chk("ill_cnt_sat", illegal_cnt, 8'hFF);
    cyc();
    chk("ill_drained", occupancy, 0);

    // x0 destination
    out_ready = 1'b0;
    fwd_rs1_addr = 5'd0;
    drive(32'h1234, 5'd0, 1'b1, 1'b1);
    cyc();
    in_valid = 1'b0;
    chk("x0_valid", out_valid, 1);
    chk("x0_we", out_we, 0);
    chk("x0_fwd", fwd_rs1_hit, 0);
    out_ready = 1'b1;
    cyc();

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    drive(32'h55, 5'd6, 1'b1, 1'b1);
    cyc();
    drive(32'h66, 5'd8, 1'b1, 1'b1);
    cyc();
    in_valid = 1'b0;
    fwd_rs1_addr = 5'd6;
    #1;
    chk("arst_pre_hit", fwd_rs1_hit, 1);
    rst = 1'b1;
    #1;
    chk("arst_occ", occupancy, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_fwd_hit", fwd_rs1_hit, 0);
    chk("arst_fwd_data", fwd_rs1_data, 0);
    chk("arst_icnt", illegal_cnt, 0);
    chk("arst_data", out_data, 0);
    chk("arst_rd", out_rd, 0);
    cyc();
    rst = 1'b0;

    // Randomised traffic, checked by the model every cycle
    repeat (3000) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      in_result    = $urandom;
      in_rd        = 5'($urandom_range(0, 7));
      in_regWrite  = ($urandom_range(0, 3) != 0);
      in_isZbb     = ($urandom_range(0, 7) != 0);
      out_ready    = ($urandom_range(0, 1) != 0);
      flush        = ($urandom_range(0, 15) == 0);
      fwd_rs1_addr = 5'($urandom_range(0, 7));
      fwd_rs2_addr = 5'($urandom_range(0, 7));
      cyc();
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
